// File: rtl/rev_count_ctrl_pkg.sv
// Shared constants for the reversible display counter controller:
// FSM state encoding, count direction values and the board-clock prescale default.
package rev_count_ctrl_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // 50 MHz board clock -> 100 count steps per second
   localparam int TICK_DIV_DEFAULT = 500000;

endpackage

// File: rtl/rev_count_ctrl_if.sv
// Command/status bundle between the button front-end, the counter controller
// and the display datapath.
interface rev_count_ctrl_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic             stop;
   logic             clear;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             running;
   logic             tick;
   logic             wrap;

   modport master (
      output start, stop, clear, dir, load, load_val,
      input  count, running, tick, wrap
   );

   modport slave (
      input  start, stop, clear, dir, load, load_val,
      output count, running, tick, wrap
   );

endinterface

// File: rtl/rev_count_ctrl_tick_gen.sv
// Single-clock prescaler producing a one-cycle step enable every TICK_DIV cycles
// while enabled; restart zeroes the prescaler.
module tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int            PW   = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PEN  = PW'(TICK_DIV - 2);

   logic [PW-1:0] prescaler_q, prescaler_d;
   logic          tick_q, tick_d;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      prescaler_d = prescaler_q;
      tick_d      = 1'b0;
      if (restart) begin
         prescaler_d = '0;
      end else if (en) begin
         prescaler_d = (prescaler_q == LAST) ? '0 : prescaler_q + PW'(1);
         // register the strobe together with the terminal prescaler value
         tick_d      = (prescaler_q == PEN);
      end
   end

   // NOTE: reset is synchronous and lives inside the clocked block; state updates use <= only.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler_q <= '0;
         tick_q      <= 1'b0;
      end else begin
         prescaler_q <= prescaler_d;
         tick_q      <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/rev_count_ctrl.sv
// Run/pause/direction controller for the reversible display counter: a 3-state FSM
// plus a modulo-MOD up/down count stepped by the tick_gen strobe.
module rev_count_ctrl
   import rev_count_ctrl_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT,
   parameter int MOD      = 100,
   parameter int WIDTH    = 8
) (
   input  logic               clk,
   input  logic               rst,
   rev_count_ctrl_if.slave    bus
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             running_q, running_d;
   logic             wrap_q, wrap_d;
   logic             tick_q;
   logic             step;
   logic             presc_en;
   logic             presc_restart;
   logic [WIDTH-1:0] load_sat;

   assign load_sat = (bus.load_val <= MAX_VAL) ? bus.load_val : MAX_VAL;

   always_comb begin
      // unused encoding falls back to IDLE
      state_d = ((state_q == S_RUN) || (state_q == S_PAUSE)) ? state_q : S_IDLE;
      count_d = count_q;
      wrap_d  = 1'b0;

      if (bus.clear) begin
         state_d = S_IDLE;
         count_d = '0;
      end else if (bus.load && (state_q != S_RUN)) begin
         count_d = load_sat;
      end else if (bus.stop) begin
         state_d = (state_q == S_RUN) ? S_PAUSE : S_IDLE;
      end else if (bus.start) begin
         state_d = S_RUN;
      end

      // a tick coinciding with stop/clear leaves RUN and is dropped
      step = tick_q && (state_d == S_RUN);
      if (step) begin
         if (bus.dir == DIR_DOWN) begin
            count_d = (count_q == '0) ? MAX_VAL : count_q - WIDTH'(1);
            wrap_d  = (count_q == '0);
         end else begin
            count_d = (count_q == MAX_VAL) ? '0 : count_q + WIDTH'(1);
            wrap_d  = (count_q == MAX_VAL);
         end
      end

      running_d     = (state_d == S_RUN);
      presc_en      = (state_d == S_RUN);
      presc_restart = bus.clear || ((state_q != S_RUN) && (state_q != S_PAUSE) && (state_d == S_RUN));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .en      (presc_en),
      .restart (presc_restart),
      .tick    (tick_q)
   );

   assign bus.count   = count_q;
   assign bus.running = running_q;
   assign bus.tick    = tick_q;
   assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_rev_count_ctrl.sv
// Scoreboard bench for rev_count_ctrl (TICK_DIV=4, MOD=10, WIDTH=4): expected
// output values are queued against a cycle number and compared on the falling edge.
module tb_rev_count_ctrl;

   typedef enum int {SIG_COUNT, SIG_RUN, SIG_TICK, SIG_WRAP} sig_e;

   typedef struct {
      int unsigned cyc;
      sig_e        sel;
      int unsigned val;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   exp_t        sb[$];

   rev_count_ctrl_if #(.WIDTH(4)) bus ();

   rev_count_ctrl #(
      .TICK_DIV (4),
      .MOD      (10),
      .WIDTH    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic [31:0] observe(input sig_e s);
      case (s)
         SIG_COUNT: observe = {28'd0, bus.count};
         SIG_RUN:   observe = {31'd0, bus.running};
         SIG_TICK:  observe = {31'd0, bus.tick};
         default:   observe = {31'd0, bus.wrap};
      endcase
   endfunction

   task automatic exp_at(input int unsigned at, input sig_e s, input int unsigned v, input string tag);
      exp_t e;
      e.cyc = at;
      e.sel = s;
      e.val = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].tag, observe(sb[i].sel), sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int unsigned t);
      while (cyc < t) step();
   endtask

   // one-cycle command pulse in the current cycle
   task automatic drive(input logic st, input logic sp, input logic cl, input logic ld,
                        input logic [3:0] lv);
      bus.start    = st;
      bus.stop     = sp;
      bus.clear    = cl;
      bus.load     = ld;
      bus.load_val = lv;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.clear = 1'b0;
      bus.load  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned b;
      int unsigned s;

      bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
      bus.dir = 1'b0; bus.load = 1'b0; bus.load_val = '0;
      rst = 1'b1;
      step(); step();
      exp_at(cyc, SIG_COUNT, 0, "rst_count");
      exp_at(cyc, SIG_RUN,   0, "rst_running");
      exp_at(cyc, SIG_TICK,  0, "rst_tick");
      exp_at(cyc, SIG_WRAP,  0, "rst_wrap");
      step();
      rst = 1'b0;
      step();

      // 1: start from IDLE, count up
      b = cyc;
      exp_at(b,      SIG_RUN,   0, "s1_run_pre");
      exp_at(b + 1,  SIG_RUN,   1, "s1_run_on");
      exp_at(b + 3,  SIG_TICK,  0, "s1_tick3");
      exp_at(b + 4,  SIG_TICK,  1, "s1_tick4");
      exp_at(b + 4,  SIG_COUNT, 0, "s1_count4");
      exp_at(b + 5,  SIG_COUNT, 1, "s1_count5");
      exp_at(b + 5,  SIG_TICK,  0, "s1_tick5");
      exp_at(b + 5,  SIG_WRAP,  0, "s1_wrap5");
      exp_at(b + 8,  SIG_TICK,  1, "s1_tick8");
      exp_at(b + 9,  SIG_COUNT, 2, "s1_count9");
      exp_at(b + 12, SIG_TICK,  1, "s1_tick12");
      exp_at(b + 13, SIG_COUNT, 3, "s1_count13");
      drive(1, 0, 0, 0, 4'd0);
      goto(b + 14);

      b = cyc;
      exp_at(b + 1, SIG_COUNT, 0, "clr_count");
      exp_at(b + 1, SIG_RUN,   0, "clr_running");
      drive(0, 0, 1, 0, 4'd0);

      // 2: load 9, wrap up to 0, then down back to 9
      b = cyc;
      exp_at(b + 1, SIG_COUNT, 9, "s2_load9");
      exp_at(b + 1, SIG_WRAP,  0, "s2_load_nowrap");
      drive(0, 0, 0, 1, 4'd9);
      b = cyc;
      exp_at(b + 1,  SIG_RUN,   1, "s2_run");
      exp_at(b + 4,  SIG_TICK,  1, "s2_tick4");
      exp_at(b + 4,  SIG_COUNT, 9, "s2_count_held");
      exp_at(b + 5,  SIG_COUNT, 0, "s2_wrap_up_count");
      exp_at(b + 5,  SIG_WRAP,  1, "s2_wrap_up");
      exp_at(b + 6,  SIG_WRAP,  0, "s2_wrap_up_end");
      exp_at(b + 8,  SIG_COUNT, 0, "s2_count_before_down");
      exp_at(b + 9,  SIG_COUNT, 9, "s2_wrap_down_count");
      exp_at(b + 9,  SIG_WRAP,  1, "s2_wrap_down");
      exp_at(b + 10, SIG_WRAP,  0, "s2_wrap_down_end");
      exp_at(b + 10, SIG_COUNT, 9, "s2_count_after_down");
      drive(1, 0, 0, 0, 4'd0);
      goto(b + 6);
      bus.dir = 1'b1;
      goto(b + 11);
      bus.dir = 1'b0;

      // 3: pause/resume keeps prescaler phase; stop in PAUSE -> IDLE
      drive(0, 0, 1, 0, 4'd0);
      s = cyc;
      exp_at(s + 4,  SIG_TICK,  1, "s3_tick4");
      exp_at(s + 5,  SIG_COUNT, 1, "s3_count5");
      exp_at(s + 7,  SIG_RUN,   0, "s3_paused");
      exp_at(s + 8,  SIG_TICK,  0, "s3_no_tick_paused");
      exp_at(s + 9,  SIG_COUNT, 1, "s3_count_paused");
      exp_at(s + 12, SIG_RUN,   1, "s3_resumed");
      exp_at(s + 12, SIG_TICK,  0, "s3_tick_resume1");
      exp_at(s + 13, SIG_TICK,  1, "s3_tick_resume2");
      exp_at(s + 14, SIG_COUNT, 2, "s3_count_resume");
      exp_at(s + 16, SIG_RUN,   0, "s3_pause2");
      exp_at(s + 18, SIG_RUN,   0, "s3_idle");
      exp_at(s + 18, SIG_COUNT, 2, "s3_idle_count");
      exp_at(s + 21, SIG_TICK,  0, "s3_restart_no_early_tick");
      exp_at(s + 23, SIG_TICK,  1, "s3_restart_tick");
      exp_at(s + 24, SIG_COUNT, 3, "s3_restart_count");
      drive(1, 0, 0, 0, 4'd0);
      goto(s + 6);  drive(0, 1, 0, 0, 4'd0);
      goto(s + 11); drive(1, 0, 0, 0, 4'd0);
      goto(s + 15); drive(0, 1, 0, 0, 4'd0);
      goto(s + 17); drive(0, 1, 0, 0, 4'd0);
      goto(s + 19); drive(1, 0, 0, 0, 4'd0);

      // 4: start+stop -> PAUSE; load ignored in RUN; clear beats load
      goto(s + 25);
      exp_at(s + 26, SIG_RUN, 0, "s4_startstop_pause");
      drive(1, 1, 0, 0, 4'd0);
      goto(s + 27);
      exp_at(s + 28, SIG_RUN,  1, "s4_resume");
      exp_at(s + 29, SIG_TICK, 1, "s4_tick");
      drive(1, 0, 0, 0, 4'd0);
      goto(s + 29);
      exp_at(s + 30, SIG_COUNT, 4, "s4_load_ignored");
      exp_at(s + 30, SIG_WRAP,  0, "s4_no_wrap");
      exp_at(s + 30, SIG_RUN,   1, "s4_still_run");
      drive(0, 0, 0, 1, 4'd7);
      goto(s + 31);
      exp_at(s + 32, SIG_COUNT, 0, "s4_clear_load_count");
      exp_at(s + 32, SIG_RUN,   0, "s4_clear_load_idle");
      drive(0, 0, 1, 1, 4'd5);

      // 5: saturating load, then reset with a tick pending
      goto(s + 33);
      exp_at(s + 34, SIG_COUNT, 9, "s5_load_sat");
      drive(0, 0, 0, 1, 4'd15);
      goto(s + 35);
      exp_at(s + 36, SIG_RUN, 1, "s5_run");
      drive(1, 0, 0, 0, 4'd0);
      goto(s + 38);
      exp_at(s + 39, SIG_COUNT, 0, "s5_rst_count");
      exp_at(s + 39, SIG_RUN,   0, "s5_rst_running");
      exp_at(s + 39, SIG_TICK,  0, "s5_rst_tick");
      exp_at(s + 39, SIG_WRAP,  0, "s5_rst_wrap");
      exp_at(s + 41, SIG_COUNT, 0, "s5_post_rst_count");
      exp_at(s + 41, SIG_TICK,  0, "s5_post_rst_tick");
      rst = 1'b1;
      step();
      rst = 1'b0;
      goto(s + 44);

      while (sb.size() > 0) begin
         check({sb[0].tag, "_never_sampled"}, 32'd1, 32'd0);
         void'(sb.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
